// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  typedef logic [3:0] nibble_t;

  // Nibble presented to the decoder whenever no digit is lit.
  localparam nibble_t SEG_BLANK = 4'h0;

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero suppression mask: digit i is dark when it and every more
// significant digit are zero. Digit 0 always stays lit.
module seg_lz_mask
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] committed,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   suppress
);

  logic all_zero;

  // Walk from the most significant digit down, tracking "all zero so far".
  always_comb begin
    suppress = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero    = all_zero && (committed[4*i +: 4] == nibble_t'(0));
      suppress[i] = lz_en && all_zero;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller: rotates committed hex digits onto a shared
// decoder with dead-time between digits and frame-aligned value commits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lz_en,
  output logic [3:0]              hex_out,
  output logic                    seg_en,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int unsigned VW      = 4 * NUM_DIGITS;
  localparam int unsigned CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_t                state, state_n;
  logic [IW-1:0]         idx, idx_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  wrap;

  logic [VW-1:0]         pending, committed;
  logic                  pend_valid;
  logic                  commit;
  logic [NUM_DIGITS-1:0] suppress;

  nibble_t               hex_n;
  logic                  seg_en_n;
  logic [NUM_DIGITS-1:0] dig_sel_n;

  seg_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lz_mask (
    .committed (committed),
    .lz_en     (lz_en),
    .suppress  (suppress)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic; wrap marks the last SHOW cycle of the final digit.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    wrap    = 1'b0;
    if (!en) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = BLANK;
          idx_n   = '0;
          cnt_n   = '0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
            if (idx == IDX_LAST) begin
              idx_n = '0;
              wrap  = 1'b1;
            end else begin
              idx_n = idx + IW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    hex_n     = SEG_BLANK;
    seg_en_n  = 1'b0;
    dig_sel_n = '0;
    if (state_n == SHOW) begin
      hex_n     = committed[4*idx_n +: 4];
      seg_en_n  = !suppress[idx_n];
      dig_sel_n = NUM_DIGITS'(1) << idx_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_out    <= SEG_BLANK;
      seg_en     <= 1'b0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      hex_out    <= hex_n;
      seg_en     <= seg_en_n;
      dig_sel    <= dig_sel_n;
      frame_done <= wrap;
    end
  end

  // Double-buffered value: commits only at frame wrap or while disabled.
  assign commit = wrap || !en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      committed  <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (load) begin
        pending <= value;
      end
      if (commit) begin
        pend_valid <= 1'b0;
        if (load) begin
          committed <= value;
        end else if (pend_valid) begin
          committed <= pending;
        end
      end else if (load) begin
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: expected digits are queued when values are
// driven and popped as each lit digit appears on dig_sel.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic        lz_en;
  logic [3:0]  hex_out;
  logic        seg_en;
  logic [3:0]  dig_sel;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] hex;
    logic       seg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_fd = 0;
  bit   last_fd_ok = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .PRESCALE     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .value      (value),
    .lz_en      (lz_en),
    .hex_out    (hex_out),
    .seg_en     (seg_en),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected per-digit output for one full frame of value v.
  function automatic void push_frame(input logic [15:0] v, input logic lz);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      e.sel = 4'(1 << d);
      e.hex = 4'(v >> (4 * d));
      e.seg = !(lz && d != 0 && (v >> (4 * d)) == 16'h0);
      q.push_back(e);
    end
  endfunction

  // Consume blank gap then one lit digit; optionally pulse load on its last SHOW cycle.
  task automatic run_digit(input bit exp_fd, input bit do_ld, input logic [15:0] ld_val);
    int         blanks;
    int         shows;
    int         bad;
    int         fds;
    exp_t       e;
    logic [3:0] sel;
    blanks = 0;
    shows  = 0;
    bad    = 0;
    fds    = 0;
    while (dig_sel === 4'b0000 && blanks < 60) begin
      if (frame_done === 1'b1) begin
        fds++;
        if (last_fd_ok) chk("frame_period", 32'(cyc - last_fd), 32'd40);
        last_fd    = cyc;
        last_fd_ok = 1;
      end
      blanks++;
      @(negedge clk);
      load = 1'b0;
    end
    chk("blank_len", 32'(blanks), 32'd2);
    if (q.size() == 0) begin
      chk("sb_underflow", 32'(q.size()), 32'd1);
      return;
    end
    e = q.pop_front();
    chk("dig_sel", 32'(dig_sel), 32'(e.sel));
    chk("hex_out", 32'(hex_out), 32'(e.hex));
    chk("seg_en", 32'(seg_en), 32'(e.seg));
    sel = dig_sel;
    while (dig_sel === sel && shows < 60) begin
      shows++;
      if (hex_out !== e.hex || seg_en !== e.seg) bad++;
      if (frame_done === 1'b1) fds++;
      if (do_ld && shows == 8) begin
        load  = 1'b1;
        value = ld_val;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    chk("show_len", 32'(shows), 32'd8);
    chk("show_stable", 32'(bad), 32'd0);
    chk("frame_done_cnt", 32'(fds), 32'(exp_fd));
  endtask

  task automatic run_frame(input bit fd_first);
    run_digit(fd_first, 0, 16'h0);
    for (int d = 1; d < 4; d++) run_digit(0, 0, 16'h0);
  endtask

  // Disable, load v (committed immediately while idle), then re-enable.
  task automatic restart(input logic [15:0] v, input logic lz);
    en    = 1'b0;
    load  = 1'b1;
    value = v;
    lz_en = lz;
    @(negedge clk);
    load = 1'b0;
    en   = 1'b1;
    q.delete();
    push_frame(v, lz);
    last_fd_ok = 0;
    @(negedge clk);
  endtask

  initial begin
    int w;
    int fds;
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    value = 16'h0;
    lz_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hex", 32'(hex_out), 32'd0);
    chk("rst_seg_en", 32'(seg_en), 32'd0);
    chk("rst_dig_sel", 32'(dig_sel), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic scan of 1234, then a mid-frame load of ABCD
    restart(16'h1234, 1'b0);
    run_frame(0);
    push_frame(16'h1234, 1'b0);
    run_digit(1, 0, 16'h0);
    run_digit(0, 0, 16'h0);
    load  = 1'b1;
    value = 16'hABCD;
    push_frame(16'hABCD, 1'b0);
    run_digit(0, 0, 16'h0);
    run_digit(0, 0, 16'h0);
    run_frame(1);

    // Leading-zero suppression
    restart(16'h0050, 1'b1);
    run_frame(0);
    restart(16'h0000, 1'b1);
    run_frame(0);

    // Overwritten pending load, then load sampled at the frame wrap
    restart(16'h9999, 1'b0);
    run_digit(0, 0, 16'h0);
    load  = 1'b1;
    value = 16'h1111;
    run_digit(0, 0, 16'h0);
    load  = 1'b1;
    value = 16'h2222;
    push_frame(16'h2222, 1'b0);
    run_digit(0, 0, 16'h0);
    run_digit(0, 0, 16'h0);
    run_digit(1, 0, 16'h0);
    run_digit(0, 0, 16'h0);
    run_digit(0, 0, 16'h0);
    run_digit(0, 1, 16'h5A3C);
    push_frame(16'h5A3C, 1'b0);
    run_digit(1, 0, 16'h0);
    run_digit(0, 0, 16'h0);

    // Drop enable during digit 2
    w = 0;
    while (dig_sel !== 4'b0100 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("digit2_reached", 32'(dig_sel), 32'h4);
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("dis_dig_sel", 32'(dig_sel), 32'd0);
    chk("dis_seg_en", 32'(seg_en), 32'd0);
    fds = 0;
    for (int i = 0; i < 6; i++) begin
      if (frame_done === 1'b1) fds++;
      @(negedge clk);
    end
    chk("dis_no_frame_done", 32'(fds), 32'd0);
    q.delete();
    push_frame(16'h5A3C, 1'b0);
    last_fd_ok = 0;
    en = 1'b1;
    @(negedge clk);
    run_frame(0);

    // Asynchronous reset mid-SHOW discards a pending load
    push_frame(16'h5A3C, 1'b0);
    load  = 1'b1;
    value = 16'h7777;
    run_digit(1, 0, 16'h0);
    w = 0;
    while (dig_sel !== 4'b0010 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("digit1_reached", 32'(dig_sel), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dig_sel", 32'(dig_sel), 32'd0);
    chk("arst_seg_en", 32'(seg_en), 32'd0);
    chk("arst_hex", 32'(hex_out), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q.delete();
    push_frame(16'h0000, 1'b0);
    last_fd_ok = 0;
    en = 1'b1;
    @(negedge clk);
    run_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
